coeff_bank: RTL and testbench
=============================

# coeff_bank

Parametrised, multi-channel filter-coefficient store for the MSDAP datapath. It replaces a flat, single-channel coefficient RAM with the following:
- A per-channel bank array.
- An auto-incrementing, handshaked load sequencer.
- A registered read port with a valid strobe.

It sits between the serial-input word assembler, which supplies coefficients during initialisation, and the per-channel filter ALUs, which read coefficients during execution.

## Interface
Parameters:
- DATA_W, 16, coefficient word width
- DEPTH, 512, coefficients per channel; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W
- ADDR_W, 9, address width
- CHANNELS, 2, number of channel banks (L/R); must be ≥ 1
- CH_W, 1, channel-select width; must be ≥ 1 and CHANNELS ≤ 2**CH_W

Ports:
- Sclk  in  1  system clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle pulse; begins a full coefficient load
- load_valid  in  1  load_data is valid this cycle
- load_data  in  DATA_W  coefficient word
- load_ready  out  1  sequencer accepts a word this cycle
- load_done  out  1  level; all CHANNELS*DEPTH words have been written since the last load_start
- busy  out  1  high in LOAD (and in CLEAR when compiled in)
- rd_en  in  1  read request
- rd_ch  in  CH_W  channel to read
- rd_addr  in  ADDR_W  coefficient index
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data updated this cycle
- clear_req  in  1  present only with COEFF_BANK_CLEAR_EN

## Operation
- Storage: CHANNELS banks of DEPTH × DATA_W words. Memory contents are not reset.
- FSM states: IDLE, LOAD, plus CLEAR with the macro.
- IDLE:
  - load_ready=0.
  - load_start → LOAD. Write pointer wptr=0, channel pointer wch=0, load_done cleared.
- LOAD:
  - load_ready=1, busy=1.
  - Each cycle with load_valid=1 writes load_data to bank[wch][wptr].
  - After each write, wptr increments. At wptr==DEPTH-1, wptr wraps to 0 and wch increments.
  - A write at wch==CHANNELS-1, wptr==DEPTH-1 is the final word. After it, the FSM returns to IDLE and load_done is set.
- load_start while in LOAD restarts the load: pointers go to 0 and load_done stays 0. When load_start and load_valid are both high, the word is written at the old pointer, then the pointers reset.
- load_valid outside LOAD is ignored.
- Read port:
  - When rd_en=1, the addressed word is sampled and presented on rd_data the next cycle, with rd_valid=1 for one cycle.
  - rd_addr ≥ DEPTH or rd_ch ≥ CHANNELS returns 0, still with rd_valid=1.
  - When rd_en=0, rd_data holds its last value and rd_valid=0.
- Reads are legal in any state. On a same-cycle read and write to the same bank and address, the read returns the old data (read-before-write).

## Timing
- Reset values:
  - State IDLE; wptr=0, wch=0.
  - load_ready=0, load_done=0, busy=0.
  - rd_data=0, rd_valid=0.
- load_ready and busy are registered and asserted the cycle after load_start is sampled.
- The final write takes effect at the edge where it is sampled. From the following cycle, load_done=1, busy=0 and load_ready=0.
- Read latency is exactly 1 cycle. Throughput is one read per cycle.
- Reset asserted mid-load aborts the load immediately. Memory keeps its partial contents and load_done=0.

## Configuration
- COEFF_BANK_CLEAR_EN defined:
  - Adds the clear_req input and a CLEAR state.
  - clear_req in IDLE → CLEAR; load_done is cleared.
  - CLEAR zeroes address cnt in all banks simultaneously, for cnt = 0..DEPTH-1 (DEPTH cycles). busy=1 and load_ready=0 throughout, then the FSM returns to IDLE.
  - clear_req during LOAD is ignored. load_start during CLEAR is ignored.
  - Reads during CLEAR return the current, possibly partially cleared, contents.
- COEFF_BANK_CLEAR_EN undefined: no clear_req port, no CLEAR state, no clear counter.

## Test plan
- Full load: reset, pulse load_start, then stream 1024 words valued 0x0000..0x03FF with load_valid held high. Required:
  - load_done rises the cycle after word 1023.
  - rd_ch=1, rd_addr=5 returns 0x0205 with rd_valid one cycle later.
- Gapped load: toggle load_valid every other cycle. Required: every word lands at its own sequential address; load_done is set only after 1024 accepted words.
- Restart: pulse load_start after 300 words, reload 1024 words of 0xA000+i. Required: ch0 addr 10 reads 0xA00A.
- Read collision: in LOAD, read ch0 addr k in the same cycle it is written. Required: old value is returned; the next read of ch0 addr k returns the new value.
- Out-of-range read: rd_ch=1, rd_addr=511 vs. a bench with DEPTH=300 and rd_addr=400. Required: valid data vs. 0x0000, with rd_valid=1 in both cases.
- Reset and clear:
  - Assert Reset_n low at word 700 of a load. Required: load_done=0 and state IDLE.
  - With COEFF_BANK_CLEAR_EN, pulse clear_req. Required: busy stays high 512 cycles; afterwards all reads return 0.

Source files
------------

// File: rtl/coeff_bank_if.sv
// Load/read bus of coeff_bank. The clear_req signal is present only when
// COEFF_BANK_CLEAR_EN is defined.
interface coeff_bank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int CH_W   = 1
);
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              busy;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
`ifdef COEFF_BANK_CLEAR_EN
  logic              clear_req;
`endif

  modport master (
`ifdef COEFF_BANK_CLEAR_EN
    output clear_req,
`endif
    output load_start, load_valid, load_data, rd_en, rd_ch, rd_addr,
    input  load_ready, load_done, busy, rd_data, rd_valid
  );

  modport slave (
`ifdef COEFF_BANK_CLEAR_EN
    input  clear_req,
`endif
    input  load_start, load_valid, load_data, rd_en, rd_ch, rd_addr,
    output load_ready, load_done, busy, rd_data, rd_valid
  );
endinterface

// File: rtl/coeff_bank.sv
// Multi-channel coefficient store with handshaked auto-increment loader and
// registered read port. Define COEFF_BANK_CLEAR_EN to add the bulk CLEAR state.
module coeff_bank #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 9,
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1
) (
  input logic        Sclk,
  input logic        Reset_n,
  coeff_bank_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
`ifdef COEFF_BANK_CLEAR_EN
  localparam logic [1:0] S_CLEAR = 2'd2;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CHANNELS - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [CH_W:0]     CHANS_X   = (CH_W + 1)'(CHANNELS);

  logic [DATA_W-1:0] mem [CHANNELS][DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] wptr;
  logic [CH_W-1:0]   wch;
  logic              load_ready_q;
  logic              load_done_q;
  logic              busy_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              wr_en;
  logic              rd_in_range;
`ifdef COEFF_BANK_CLEAR_EN
  logic [ADDR_W-1:0] cnt;
`endif

  assign wr_en       = (state == S_LOAD) && bus.load_valid;
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_X) && ({1'b0, bus.rd_ch} < CHANS_X);

  assign bus.load_ready = load_ready_q;
  assign bus.load_done  = load_done_q;
  assign bus.busy       = busy_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      wptr         <= '0;
      wch          <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef COEFF_BANK_CLEAR_EN
      cnt          <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.load_start) begin
            state        <= S_LOAD;
            wptr         <= '0;
            wch          <= '0;
            load_done_q  <= 1'b0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
`ifdef COEFF_BANK_CLEAR_EN
          else if (bus.clear_req) begin
            state       <= S_CLEAR;
            cnt         <= '0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b1;
          end
`endif
        end
        S_LOAD: begin
          // Restart wins over pointer advance; the coincident word is still
          // written at the old pointer by the memory process.
          if (bus.load_start) begin
            wptr <= '0;
            wch  <= '0;
          end else if (bus.load_valid) begin
            if (wptr == LAST_ADDR) begin
              wptr <= '0;
              if (wch == LAST_CH) begin
                state        <= S_IDLE;
                wch          <= '0;
                load_done_q  <= 1'b1;
                load_ready_q <= 1'b0;
                busy_q       <= 1'b0;
              end else begin
                wch <= wch + CH_W'(1);
              end
            end else begin
              wptr <= wptr + ADDR_W'(1);
            end
          end
        end
`ifdef COEFF_BANK_CLEAR_EN
        S_CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Sclk) begin
    if (wr_en) mem[wch][wptr] <= bus.load_data;
`ifdef COEFF_BANK_CLEAR_EN
    if (state == S_CLEAR) begin
      for (int unsigned c = 0; c < CHANNELS; c++) mem[c][cnt] <= '0;
    end
`endif
  end

  // Nonblocking memory update gives read-before-write on address collisions.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_in_range ? mem[bus.rd_ch][bus.rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_coeff_bank.sv
// Scoreboard bench for coeff_bank: a reference memory model feeds expected
// read data into a queue that is popped when rd_valid is sampled.
module tb_coeff_bank;
  localparam int DEPTH = 512;

  logic Sclk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Sclk = ~Sclk;

  coeff_bank_if #(.DATA_W(16), .ADDR_W(9), .CH_W(1)) bus ();
  coeff_bank_if #(.DATA_W(16), .ADDR_W(9), .CH_W(1)) bus3 ();

  coeff_bank #(.DATA_W(16), .DEPTH(512), .ADDR_W(9), .CHANNELS(2), .CH_W(1)) dut (
    .Sclk(Sclk), .Reset_n(Reset_n), .bus(bus)
  );
  coeff_bank #(.DATA_W(16), .DEPTH(300), .ADDR_W(9), .CHANNELS(1), .CH_W(1)) dut300 (
    .Sclk(Sclk), .Reset_n(Reset_n), .bus(bus3)
  );

  int passed = 0;
  int total = 0;
  int widx = 0;
  logic [15:0] model [2][DEPTH];
  logic [15:0] exp_q [$];

  task automatic start_load();
    bus.load_start = 1'b1;
    @(negedge Sclk);
    bus.load_start = 1'b0;
    widx = 0;
  endtask

  task automatic load_words(input int n, input logic [15:0] base, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        bus.load_valid = 1'b0;
        @(negedge Sclk);
      end
      bus.load_valid = 1'b1;
      bus.load_data = base + 16'(widx);
      model[widx / DEPTH][widx % DEPTH] = bus.load_data;
      widx++;
      @(negedge Sclk);
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic issue_read(input int ch, input int addr);
    bus.rd_en = 1'b1;
    bus.rd_ch = 1'(ch);
    bus.rd_addr = 9'(addr);
    exp_q.push_back(model[ch][addr]);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Sclk);
    total++;
    if ({bus.load_ready, bus.load_done, bus.busy, bus.rd_valid} !== 4'b0000)
      $display("FAIL reset_flags got %b exp 0000", {bus.load_ready, bus.load_done, bus.busy, bus.rd_valid});
    else passed++;
    total++;
    if (bus.rd_data !== 16'h0000) $display("FAIL reset_rd_data got %h exp 0000", bus.rd_data);
    else passed++;
    Reset_n = 1'b1;
    @(negedge Sclk);
  endtask

  task automatic test_full_load();
    int chs [5] = '{1, 0, 0, 1, 1};
    int adrs [5] = '{5, 0, 511, 0, 511};
    logic [15:0] e;
    start_load();
    total++;
    if ({bus.load_ready, bus.busy, bus.load_done} !== 3'b110)
      $display("FAIL full_start got %b exp 110", {bus.load_ready, bus.busy, bus.load_done});
    else passed++;
    load_words(1023, 16'h0000, 1'b0);
    total++;
    if ({bus.load_ready, bus.busy, bus.load_done} !== 3'b110)
      $display("FAIL full_before_last got %b exp 110", {bus.load_ready, bus.busy, bus.load_done});
    else passed++;
    load_words(1, 16'h0000, 1'b0);
    total++;
    if ({bus.load_ready, bus.busy, bus.load_done} !== 3'b001)
      $display("FAIL full_done got %b exp 001", {bus.load_ready, bus.busy, bus.load_done});
    else passed++;
    for (int i = 0; i < 5; i++) begin
      issue_read(chs[i], adrs[i]);
      @(negedge Sclk);
      e = exp_q.pop_front();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e)
        $display("FAIL full_read%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, e);
      else passed++;
    end
    bus.rd_en = 1'b0;
    @(negedge Sclk);
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h03FF)
      $display("FAIL read_hold got v=%b d=%h exp v=0 d=03ff", bus.rd_valid, bus.rd_data);
    else passed++;
  endtask

  task automatic test_gapped();
    int chs [4] = '{0, 0, 1, 1};
    int adrs [4] = '{1, 2, 510, 511};
    logic [15:0] e;
    start_load();
    load_words(1023, 16'h5000, 1'b1);
    total++;
    if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b1)
      $display("FAIL gap_early_done got done=%b rdy=%b exp done=0 rdy=1", bus.load_done, bus.load_ready);
    else passed++;
    load_words(1, 16'h5000, 1'b1);
    total++;
    if (bus.load_done !== 1'b1) $display("FAIL gap_done got %b exp 1", bus.load_done);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      issue_read(chs[i], adrs[i]);
      @(negedge Sclk);
      e = exp_q.pop_front();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e)
        $display("FAIL gap_read%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, e);
      else passed++;
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_restart();
    logic [15:0] e;
    start_load();
    load_words(300, 16'h1111, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data = 16'h1111 + 16'(widx);
    model[0][widx] = bus.load_data;
    bus.load_start = 1'b1;
    @(negedge Sclk);
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    widx = 0;
    total++;
    if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b1)
      $display("FAIL restart_flags got done=%b rdy=%b exp done=0 rdy=1", bus.load_done, bus.load_ready);
    else passed++;
    load_words(1024, 16'hA000, 1'b0);
    total++;
    if (bus.load_done !== 1'b1) $display("FAIL restart_done got %b exp 1", bus.load_done);
    else passed++;
    issue_read(0, 10);
    @(negedge Sclk);
    e = exp_q.pop_front();
    total++;
    if (bus.rd_data !== e || e !== 16'hA00A)
      $display("FAIL restart_read got %h exp %h", bus.rd_data, 16'hA00A);
    else passed++;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_collision();
    logic [15:0] e;
    start_load();
    load_words(20, 16'hC000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue_read(0, 20);
      bus.load_valid = 1'b1;
      bus.load_data = 16'hC000 + 16'(widx);
      model[0][widx] = bus.load_data;
      widx++;
      if (k == 1) issue_read(0, 20);
      @(negedge Sclk);
      e = exp_q.pop_front();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e)
        $display("FAIL collision%0d got v=%b d=%h exp v=1 d=%h", k, bus.rd_valid, bus.rd_data, e);
      else passed++;
    end
    bus.rd_en = 1'b0;
    load_words(1024 - 22, 16'hC000, 1'b0);
    total++;
    if (bus.load_done !== 1'b1) $display("FAIL collision_done got %b exp 1", bus.load_done);
    else passed++;
  endtask

  task automatic test_out_of_range();
    int adrs [4] = '{299, 400, 5, 0};
    int chs [4] = '{0, 0, 1, 0};
    logic [15:0] e;
    bus3.load_start = 1'b1;
    @(negedge Sclk);
    bus3.load_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus3.load_valid = 1'b1;
      bus3.load_data = 16'h8000 + 16'(i);
      @(negedge Sclk);
    end
    bus3.load_valid = 1'b0;
    total++;
    if (bus3.load_done !== 1'b1) $display("FAIL small_done got %b exp 1", bus3.load_done);
    else passed++;
    exp_q.push_back(16'h812B);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h8000);
    for (int i = 0; i < 4; i++) begin
      bus3.rd_en = 1'b1;
      bus3.rd_ch = 1'(chs[i]);
      bus3.rd_addr = 9'(adrs[i]);
      @(negedge Sclk);
      e = exp_q.pop_front();
      total++;
      if (bus3.rd_valid !== 1'b1 || bus3.rd_data !== e)
        $display("FAIL oor_read%0d got v=%b d=%h exp v=1 d=%h", i, bus3.rd_valid, bus3.rd_data, e);
      else passed++;
    end
    bus3.rd_en = 1'b0;
  endtask

`ifdef COEFF_BANK_CLEAR_EN
  task automatic test_clear();
    int n = 0;
    int chs [3] = '{0, 1, 0};
    int adrs [3] = '{0, 511, 100};
    logic [15:0] e;
    bus.clear_req = 1'b1;
    @(negedge Sclk);
    bus.clear_req = 1'b0;
    total++;
    if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b0)
      $display("FAIL clear_flags got done=%b rdy=%b exp 0 0", bus.load_done, bus.load_ready);
    else passed++;
    while (bus.busy === 1'b1 && n < 2000) begin
      n++;
      bus.load_start = (n == 100);
      @(negedge Sclk);
    end
    bus.load_start = 1'b0;
    total++;
    if (n !== 512) $display("FAIL clear_busy_cycles got %0d exp 512", n);
    else passed++;
    @(negedge Sclk);
    total++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL clear_idle got rdy=%b busy=%b exp 0 0", bus.load_ready, bus.busy);
    else passed++;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < DEPTH; a++) model[c][a] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      issue_read(chs[i], adrs[i]);
      @(negedge Sclk);
      e = exp_q.pop_front();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e)
        $display("FAIL clear_read%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, e);
      else passed++;
    end
    bus.rd_en = 1'b0;
  endtask
`endif

  task automatic test_reset_midload();
    int chs [3] = '{0, 1, 1};
    int adrs [3] = '{5, 187, 188};
    logic [15:0] e;
    start_load();
    load_words(700, 16'h7000, 1'b0);
    Reset_n = 1'b0;
    #1;
    total++;
    if ({bus.load_ready, bus.load_done, bus.busy, bus.rd_valid} !== 4'b0000)
      $display("FAIL midreset_flags got %b exp 0000", {bus.load_ready, bus.load_done, bus.busy, bus.rd_valid});
    else passed++;
    @(negedge Sclk);
    Reset_n = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 16'hDEAD;
    repeat (3) @(negedge Sclk);
    bus.load_valid = 1'b0;
    total++;
    if ({bus.load_ready, bus.busy, bus.load_done} !== 3'b000)
      $display("FAIL midreset_idle got %b exp 000", {bus.load_ready, bus.busy, bus.load_done});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      issue_read(chs[i], adrs[i]);
      @(negedge Sclk);
      e = exp_q.pop_front();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e)
        $display("FAIL midreset_read%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, e);
      else passed++;
    end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < DEPTH; a++) model[c][a] = 16'h0000;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
    bus.rd_en = 1'b0; bus.rd_ch = '0; bus.rd_addr = '0;
    bus3.load_start = 1'b0; bus3.load_valid = 1'b0; bus3.load_data = '0;
    bus3.rd_en = 1'b0; bus3.rd_ch = '0; bus3.rd_addr = '0;
`ifdef COEFF_BANK_CLEAR_EN
    bus.clear_req = 1'b0;
    bus3.clear_req = 1'b0;
`endif
    test_reset();
    test_full_load();
    test_gapped();
    test_restart();
    test_collision();
    test_out_of_range();
`ifdef COEFF_BANK_CLEAR_EN
    test_clear();
`endif
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
